// File: rtl/button_cmd_arbiter.sv
// button_cmd_arbiter: latches one-cycle button pulses into a pending vector
// and offers them one at a time, round-robin, as a valid/ready command
// stream. Each accepted command is followed by a fixed hold-off gap.
//
// Handshake: cmd_valid/cmd_idx are raised by the arbiter and held stable
// until cmd_valid & cmd_ready is seen at a clk edge; that edge is the
// transfer. cmd_ready while cmd_valid is low has no effect, and cmd_valid
// never depends combinationally on cmd_ready.
module button_cmd_arbiter #(
  parameter int NUM_BTN    = 4,
  parameter int IDX_W      = 2,
  parameter int GAP_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_pulse,
  output logic               cmd_valid,
  output logic [IDX_W-1:0]   cmd_idx,
  input  logic               cmd_ready,
  output logic [NUM_BTN-1:0] pending,
  output logic               overflow,
  output logic [1:0]         fsm_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Counter only has to reach GAP_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]         state_q;
  logic [IDX_W-1:0]   rr_q;
  logic [CNT_W-1:0]   gap_cnt_q;
  logic [NUM_BTN-1:0] pending_q;
  logic               overflow_q;
  logic               valid_q;
  logic [IDX_W-1:0]   idx_q;

  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic               grant_fire;
  logic               accept;
  logic [NUM_BTN-1:0] clr_mask;
  logic [NUM_BTN-1:0] pending_d;
  logic               merge_hit;

  // Round-robin scan of the registered pending vector starting at rr_q.
  always_comb begin : rr_scan
    int j;
    sel_found = 1'b0;
    sel_idx   = '0;
    j         = 0;
    for (int k = 0; k < NUM_BTN; k++) begin
      j = (int'(rr_q) + k) % NUM_BTN;
      if (!sel_found && pending_q[j]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(j);
      end
    end
  end

  // Grant clears the chosen bit; a pulse on the same edge re-arms it and
  // is not a merge, since the old request is leaving.
  always_comb begin
    grant_fire = (state_q == ST_IDLE) && sel_found;
    accept     = (state_q == ST_GRANT) && valid_q && cmd_ready;
    clr_mask   = grant_fire ? (NUM_BTN'(1) << sel_idx) : '0;
    pending_d  = (pending_q & ~clr_mask) | btn_pulse;
    merge_hit  = |(btn_pulse & pending_q & ~clr_mask);
  end

  // Pending vector and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (merge_hit) overflow_q <= 1'b1;
    end
  end

  // Control FSM: IDLE -> GRANT -> (GAP ->) IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      rr_q      <= '0;
      gap_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_fire) begin
            state_q <= ST_GRANT;
            valid_q <= 1'b1;
            idx_q   <= sel_idx;
          end
        end
        ST_GRANT: begin
          if (accept) begin
            valid_q <= 1'b0;
            rr_q    <= IDX_W'((int'(idx_q) + 1) % NUM_BTN);
            if (GAP_CYCLES == 0) begin
              state_q <= ST_IDLE;
            end else begin
              state_q   <= ST_GAP;
              gap_cnt_q <= '0;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_idx   = idx_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_button_cmd_arbiter.sv
// Bench for button_cmd_arbiter: directed scenarios with an expected-grant
// queue; a negedge monitor pops and compares on every handshake.
module tb_button_cmd_arbiter;

  localparam int NUM_BTN    = 4;
  localparam int IDX_W      = 2;
  localparam int GAP_CYCLES = 16;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NUM_BTN-1:0] btn_pulse = '0;
  logic               cmd_valid;
  logic [IDX_W-1:0]   cmd_idx;
  logic               cmd_ready = 1'b0;
  logic [NUM_BTN-1:0] pending;
  logic               overflow;
  logic [1:0]         fsm_state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [IDX_W-1:0] exp_q[$];
  int               acc_q[$];

  button_cmd_arbiter #(
    .NUM_BTN(NUM_BTN), .IDX_W(IDX_W), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .btn_pulse(btn_pulse), .cmd_valid(cmd_valid),
    .cmd_idx(cmd_idx), .cmd_ready(cmd_ready), .pending(pending),
    .overflow(overflow), .fsm_state(fsm_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // scoreboard monitor: a handshake seen here transfers at the next edge
  always @(negedge clk) begin
    if (rst && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_grant", {28'd0, 2'd0, cmd_idx}, 32'hFFFF_FFFF);
      end else begin
        chk("grant_idx", {30'd0, cmd_idx}, {30'd0, exp_q.pop_front()});
      end
      acc_q.push_back(cyc + 1);
    end
    if (rst && fsm_state == S_GAP) chk("gap_valid", {31'd0, cmd_valid}, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [NUM_BTN-1:0] m);
    btn_pulse = m;
    tick();
    btn_pulse = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    btn_pulse = '0;
    repeat (3) tick();
    chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_idx", {30'd0, cmd_idx}, 32'd0);
    chk("rst_pending", {28'd0, pending}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_state", {30'd0, fsm_state}, {30'd0, S_IDLE});
    rst = 1'b1;
    acc_q.delete();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain", exp_q.size(), 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((fsm_state != S_IDLE || pending != '0) && n < budget) begin
      tick();
      n++;
    end
    chk("idle", {30'd0, fsm_state}, {30'd0, S_IDLE});
  endtask

  initial begin
    int k;
    // 1: single request, latency and gap length
    cmd_ready = 1'b1;
    do_reset();
    repeat (5) tick();
    exp_q.push_back(2'd2);
    pulse(4'b0100);
    k = cyc;
    chk("t1_pend", {28'd0, pending}, 32'h4);
    chk("t1_nov", {31'd0, cmd_valid}, 32'd0);
    tick();
    chk("t1_valid", {31'd0, cmd_valid}, 32'd1);
    chk("t1_idx", {30'd0, cmd_idx}, 32'd2);
    chk("t1_pend0", {28'd0, pending}, 32'd0);
    tick();
    chk("t1_drop", {31'd0, cmd_valid}, 32'd0);
    chk("t1_acc", acc_q.size() > 0 ? acc_q[0] : -1, k + 2);
    for (int i = 0; i < GAP_CYCLES; i++) begin
      if (i > 0) tick();
      chk("t1_gap", {30'd0, fsm_state}, {30'd0, S_GAP});
      chk("t1_gpend", {28'd0, pending}, 32'd0);
    end
    tick();
    chk("t1_idle", {30'd0, fsm_state}, {30'd0, S_IDLE});
    chk("t1_idx_hold", {30'd0, cmd_idx}, 32'd2);

    // 2: round-robin order and spacing
    do_reset();
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    pulse(4'b1011);
    k = cyc;
    wait_drain(120);
    chk("t2_n", acc_q.size(), 32'd3);
    if (acc_q.size() == 3) begin
      chk("t2_lat", acc_q[0], k + 2);
      chk("t2_sp1", acc_q[1] - acc_q[0], GAP_CYCLES + 2);
      chk("t2_sp2", acc_q[2] - acc_q[1], GAP_CYCLES + 2);
    end
    wait_idle(40);
    exp_q.push_back(2'd0); exp_q.push_back(2'd3);
    pulse(4'b1001);
    wait_drain(80);
    wait_idle(40);

    // 3: backpressure with a request arriving during the stall
    cmd_ready = 1'b0;
    do_reset();
    exp_q.push_back(2'd1);
    pulse(4'b0010);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid", {31'd0, cmd_valid}, 32'd1);
      chk("t3_idx", {30'd0, cmd_idx}, 32'd1);
      if (i == 1) begin
        btn_pulse = 4'b1000;
        exp_q.push_back(2'd3);
      end
      tick();
      btn_pulse = '0;
    end
    cmd_ready = 1'b1;
    chk("t3_valid6", {31'd0, cmd_valid}, 32'd1);
    chk("t3_idx6", {30'd0, cmd_idx}, 32'd1);
    chk("t3_pend", {28'd0, pending}, 32'h8);
    tick();
    chk("t3_gap", {30'd0, fsm_state}, {30'd0, S_GAP});
    wait_drain(60);
    wait_idle(40);

    // 4: merge during GAP sets sticky overflow, one grant only
    do_reset();
    exp_q.push_back(2'd2);
    pulse(4'b0100);
    tick(); tick();
    exp_q.push_back(2'd0);
    pulse(4'b0001);
    chk("t4_pend1", {28'd0, pending}, 32'h1);
    chk("t4_ov0", {31'd0, overflow}, 32'd0);
    tick(); tick();
    pulse(4'b0001);
    chk("t4_pend2", {28'd0, pending}, 32'h1);
    chk("t4_ov1", {31'd0, overflow}, 32'd1);
    chk("t4_st", {30'd0, fsm_state}, {30'd0, S_GAP});
    wait_drain(60);
    repeat (25) tick();
    chk("t4_sticky", {31'd0, overflow}, 32'd1);
    chk("t4_pend0", {28'd0, pending}, 32'd0);

    // 5: re-request on the granting edge
    do_reset();
    exp_q.push_back(2'd2); exp_q.push_back(2'd2);
    pulse(4'b0100);
    pulse(4'b0100);
    chk("t5_valid", {31'd0, cmd_valid}, 32'd1);
    chk("t5_pend", {28'd0, pending}, 32'h4);
    chk("t5_ov", {31'd0, overflow}, 32'd0);
    wait_drain(60);
    wait_idle(40);
    chk("t5_ov_end", {31'd0, overflow}, 32'd0);

    // 6: reset while a command is offered
    do_reset();
    exp_q.push_back(2'd2);
    pulse(4'b0100);
    wait_drain(20);
    wait_idle(40);
    cmd_ready = 1'b0;
    pulse(4'b0111);
    tick();
    chk("t6_st", {30'd0, fsm_state}, {30'd0, S_GRANT});
    chk("t6_idx", {30'd0, cmd_idx}, 32'd0);
    chk("t6_pend", {28'd0, pending}, 32'h6);
    rst = 1'b0;
    tick();
    chk("t6_valid", {31'd0, cmd_valid}, 32'd0);
    chk("t6_pend0", {28'd0, pending}, 32'd0);
    chk("t6_ov", {31'd0, overflow}, 32'd0);
    chk("t6_idle", {30'd0, fsm_state}, {30'd0, S_IDLE});
    rst = 1'b1;
    cmd_ready = 1'b1;
    exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    pulse(4'b1010);
    wait_drain(80);
    wait_idle(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
